seg7_scan_hex: RTL and testbench
================================

SEG7_SCAN_HEX -- requirements
Module: seg7_scan_hex

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed hex digits, legal range 1..8.
REQ-002 SHALL have parameter DIV_BITS, default 18: refresh prescaler width, legal range 2..24.
REQ-003 SHALL have input clk, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have input clr, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have input data, 4*DIGITS bits: hex value to display; data[3:0] is digit 0 (rightmost).
REQ-006 SHALL have input load, 1 bit: when high, captures data, dp_in and blank into shadow registers.
REQ-007 SHALL have input dp_in, DIGITS bits: per-digit decimal point request, 1 = lit.
REQ-008 SHALL have input blank, DIGITS bits: per-digit force-off, 1 = digit dark.
REQ-009 SHALL have input lz_en, 1 bit: leading-zero suppression enable; not captured by load.
REQ-010 SHALL have output a_to_g, 7 bits, registered: segments a (bit 6) to g (bit 0), active-low.
REQ-011 SHALL have output dp, 1 bit, registered: decimal point, active-low.
REQ-012 SHALL have output an, DIGITS bits, registered: digit anodes, active-low one-hot.

Function
REQ-013 Prescaler cnt (DIV_BITS bits) SHALL increment every cycle; tick = (cnt == all ones); cnt SHALL wrap to 0 on tick.
REQ-014 Digit index idx SHALL advance on tick, wrapping from DIGITS-1 to 0; on all other cycles idx SHALL hold.
REQ-015 Shadow registers SHALL update on the edge where load=1, independent of tick; display SHALL use shadow values only.
REQ-016 Output registers SHALL update every cycle from the current idx, shadow and lz_en, giving 1-cycle latency from any idx or shadow change to the pins.
REQ-017 Nibble-to-segment map (a_to_g, hex) SHALL be: 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F 8:00 9:04 A:08 B:60 C:31 D:42 E:30 F:38.
REQ-018 Digit idx SHALL be dark when shadow blank[idx]=1, or when lz_en=1, idx!=0, and shadow nibbles idx..DIGITS-1 are all zero.
REQ-019 For a lit digit: an SHALL be all ones except bit idx = 0; a_to_g SHALL follow REQ-017; dp SHALL equal ~dp_in_shadow[idx].
REQ-020 For a dark digit: an, a_to_g and dp SHALL all be ones.
REQ-021 Digit 0 SHALL never be suppressed by lz_en; a value of 0 SHALL display a single "0".
REQ-022 Simultaneous load and tick SHALL both take effect on the same edge; the next output update SHALL use the new idx and new shadow.
REQ-023 an SHALL never have more than one bit low in any cycle.

Reset
REQ-024 On clk edge with clr=1: cnt=0, idx=0, all shadow registers=0, a_to_g=7'h7F, dp=1, an=all ones.
REQ-025 clr SHALL take priority over load and tick; clr mid-scan SHALL restart scanning at digit 0 with a full prescaler period.
REQ-026 First output update after clr release SHALL show digit 0 of the zeroed shadow (a_to_g=7'h01, an=...1110) unless blank/lz rules apply.

Verification (DIGITS=4, DIV_BITS=2: tick every 4 cycles)
REQ-027 clr 1 cycle, then load data=16'h12AF, dp_in=0, blank=0, lz_en=0 -> an cycles 1110,1101,1011,0111 every 4 cycles with a_to_g 38,08,12,4F.
REQ-028 data=16'h0050, lz_en=1 -> digits 3,2 dark (an=1111, a_to_g=7F in those slots); digit 1 shows 24, digit 0 shows 01.
REQ-029 data=16'h0000, lz_en=1 -> only digit 0 lit with a_to_g=01; other slots all ones.
REQ-030 blank=4'b0100, dp_in=4'b0001, data=16'h8888 -> digit 2 slot all ones; digit 0 dp=0, others dp=1; lit digits a_to_g=00.
REQ-031 load asserted on the tick edge from idx 1 to 2 with new data nibble 2 = 'hC -> next cycle a_to_g=31, an=1011.
REQ-032 clr asserted while idx=3 -> next cycle idx=0, outputs at reset values; check an one-hot-low or all ones throughout.

Source files
------------

// File: rtl/seg7_scan_hex.sv
// Multiplexed hex 7-segment driver: load-captured shadow, prescaled digit scan, active-low pins.
// Pins are registered one cycle after any idx/shadow change; no flow control, load always accepted.
module seg7_scan_hex #(
  parameter int DIGITS   = 4,
  parameter int DIV_BITS = 18
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  output logic [6:0]            a_to_g,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  logic [DIV_BITS-1:0] cnt;
  logic                tick;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;

  logic [DIGITS-1:0]   upper_zero;
  logic                zacc;
  logic [3:0]          nib;
  logic                dark;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;
  logic [DIGITS-1:0]   an_nxt;

  assign tick = &cnt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h01;
      4'h1: hex_to_seg = 7'h4F;
      4'h2: hex_to_seg = 7'h12;
      4'h3: hex_to_seg = 7'h06;
      4'h4: hex_to_seg = 7'h4C;
      4'h5: hex_to_seg = 7'h24;
      4'h6: hex_to_seg = 7'h20;
      4'h7: hex_to_seg = 7'h0F;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h04;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h60;
      4'hC: hex_to_seg = 7'h31;
      4'hD: hex_to_seg = 7'h42;
      4'hE: hex_to_seg = 7'h30;
      default: hex_to_seg = 7'h38;
    endcase
  endfunction

  always_comb begin
    // upper_zero[i]: nibbles i..DIGITS-1 of the shadow are all zero
    zacc       = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zacc          = zacc & (sh_data[4*i +: 4] == 4'h0);
      upper_zero[i] = zacc;
    end
    nib  = sh_data[4*idx +: 4];
    dark = sh_blank[idx] | (lz_en & (idx != '0) & upper_zero[idx]);
    if (dark) begin
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
      an_nxt  = '1;
    end else begin
      seg_nxt = hex_to_seg(nib);
      dp_nxt  = ~sh_dp[idx];
      an_nxt  = ~(DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt      <= '0;
      idx      <= '0;
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      a_to_g   <= 7'h7F;
      dp       <= 1'b1;
      an       <= '1;
    end else begin
      cnt <= cnt + DIV_BITS'(1);
      if (tick)
        idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);
      if (load) begin
        sh_data  <= data;
        sh_dp    <= dp_in;
        sh_blank <= blank;
      end
      a_to_g <= seg_nxt;
      dp     <= dp_nxt;
      an     <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_hex.sv
// Randomized bench for seg7_scan_hex (DIGITS=4, DIV_BITS=2) against a cycle-count reference model.
module tb_seg7_scan_hex;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] data;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        lz_en;
  logic [6:0]  a_to_g;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  // model state: edges since last clr, shadow copies
  int          m_cyc;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;

  localparam logic [6:0] SEG [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  seg7_scan_hex #(.DIGITS(4), .DIV_BITS(2)) dut (
    .clk(clk), .clr(clr), .data(data), .load(load), .dp_in(dp_in),
    .blank(blank), .lz_en(lz_en), .a_to_g(a_to_g), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // expected {a_to_g, dp, an} for digit slot idx
  function automatic logic [11:0] disp(input int idx, input logic [15:0] d, input logic [3:0] dpv,
                                       input logic [3:0] bl, input logic lz);
    logic [3:0] nib;
    logic       dark;
    logic [3:0] onehot;
    nib    = 4'((d >> (4 * idx)) & 16'hF);
    dark   = bl[idx] || (lz && idx != 0 && (d >> (4 * idx)) == 16'h0);
    onehot = 4'(1 << idx);
    if (dark) return {7'h7F, 1'b1, 4'hF};
    return {SEG[nib], ~dpv[idx], ~onehot};
  endfunction

  task automatic step();
    logic [11:0] e;
    int idx;
    idx = (m_cyc / 4) % 4;
    if (clr) e = {7'h7F, 1'b1, 4'hF};
    else     e = disp(idx, m_data, m_dp, m_blank, lz_en);
    if (clr) begin
      m_cyc = 0; m_data = '0; m_dp = '0; m_blank = '0;
    end else begin
      m_cyc++;
      if (load) begin
        m_data = data; m_dp = dp_in; m_blank = blank;
      end
    end
    @(posedge clk);
    #1;
    check("a_to_g", 32'(a_to_g), 32'(e[11:5]));
    check("dp", 32'(dp), 32'(e[4]));
    check("an", 32'(an), 32'(e[3:0]));
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
    data = d; dp_in = dpv; blank = bl; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    m_cyc = 0; m_data = '0; m_dp = '0; m_blank = '0;
    clr = 1'b1; data = '0; load = 1'b0; dp_in = '0; blank = '0; lz_en = 1'b0;
    #2;
    step();
    clr = 1'b0;
    check("reset_seg", 32'(a_to_g), 32'h7F);
    check("reset_an", 32'(an), 32'hF);

    // basic scan of 12AF
    do_load(16'h12AF, 4'h0, 4'h0);
    check("first_after_clr_seg", 32'(a_to_g), 32'h01);
    check("first_after_clr_an", 32'(an), 32'hE);
    run(20);

    // leading-zero suppression cases
    lz_en = 1'b1;
    do_load(16'h0050, 4'h0, 4'h0);
    run(20);
    do_load(16'h0000, 4'h0, 4'h0);
    run(20);
    lz_en = 1'b0;

    // blank and decimal point
    do_load(16'h8888, 4'b0001, 4'b0100);
    run(20);

    // load on the tick edge from idx 1 to idx 2
    while (m_cyc % 16 != 7) step();
    do_load(16'hFCFF, 4'h0, 4'h0);
    step();
    check("load_on_tick_seg", 32'(a_to_g), 32'h31);
    check("load_on_tick_an", 32'(an), 32'hB);

    // clr mid-scan at digit 3
    while ((m_cyc % 16) < 12) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_mid_seg", 32'(a_to_g), 32'h7F);
    check("clr_mid_dp", 32'(dp), 32'h1);
    check("clr_mid_an", 32'(an), 32'hF);
    step();
    check("restart_seg", 32'(a_to_g), 32'h01);
    check("restart_an", 32'(an), 32'hE);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clr  = ($urandom_range(0, 63) == 0);
      load = ($urandom_range(0, 7) == 0);
      data = 16'($urandom);
      if ($urandom_range(0, 1) == 0) data = data & 16'h00FF;
      dp_in = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
      step();
    end
    clr = 1'b0; load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
